// File: rtl/byte_word_packer_if.sv
// Byte-in / word-out handshake bundle for byte_word_packer.
// master drives bytes and consumes words; slave is the packer.
interface byte_word_packer_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_sync;
  logic        in_ready;
  logic [31:0] out_word;
  logic [9:0]  out_sum;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output in_data, in_valid, in_sync, out_ready,
    input  in_ready, out_word, out_sum, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_sync, out_ready,
    output in_ready, out_word, out_sum, out_valid
  );
endinterface

// File: rtl/byte_word_packer.sv
// Packs a byte stream into 32-bit words (first byte in 31:24) with a
// 10-bit byte sum; in_sync realigns and counts discarded partials.
module byte_word_packer #(
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  byte_word_packer_if.slave bus,
  output logic [1:0]        byte_cnt,
  output logic [DROP_W-1:0] drop_cnt
);

  logic [7:0]  b0, b1, b2;
  logic [9:0]  psum;
  logic [31:0] word_q;
  logic [9:0]  sum_q;
  logic        valid_q;
  logic        accept;
  logic        drain;
  logic [9:0]  din_ext;

  assign bus.in_ready  = !(byte_cnt == 2'd3 && valid_q && !bus.out_ready);
  assign bus.out_word  = word_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_valid = valid_q;

  assign accept  = bus.in_valid && bus.in_ready;
  assign drain   = valid_q && bus.out_ready;
  assign din_ext = {2'b00, bus.in_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b0       <= '0;
      b1       <= '0;
      b2       <= '0;
      psum     <= '0;
      byte_cnt <= '0;
      drop_cnt <= '0;
      word_q   <= '0;
      sum_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (drain)
        valid_q <= 1'b0;
      if (accept) begin
        unique case (1'b1)
          bus.in_sync: begin
            b0       <= bus.in_data;
            psum     <= din_ext;
            byte_cnt <= 2'd1;
            if (byte_cnt != 2'd0 && drop_cnt != '1)
              drop_cnt <= drop_cnt + 1'b1;
          end
          default: begin
            unique case (byte_cnt)
              2'd0: begin
                b0       <= bus.in_data;
                psum     <= din_ext;
                byte_cnt <= 2'd1;
              end
              2'd1: begin
                b1       <= bus.in_data;
                psum     <= psum + din_ext;
                byte_cnt <= 2'd2;
              end
              2'd2: begin
                b2       <= bus.in_data;
                psum     <= psum + din_ext;
                byte_cnt <= 2'd3;
              end
              default: begin
                // completion overrides a same-edge drain
                word_q   <= {b0, b1, b2, bus.in_data};
                sum_q    <= psum + din_ext;
                valid_q  <= 1'b1;
                psum     <= '0;
                byte_cnt <= 2'd0;
              end
            endcase
          end
        endcase
      end
    end
  end

endmodule
